// File: rtl/silly_function_pkg.sv
`default_nettype none
// ============================================================================
// Module      : silly_function_pkg
// Description : Shared constants and helpers for the silly-function evaluator.
//               y = a'b'c' + ab'c' + ab'c  ==  ~b & (a | ~c)
// Revision    : 1.0 - initial release
// ============================================================================
package silly_function_pkg;

    // Truth table of one lane, bit index = {a,b,c}
    localparam logic [7:0] TRUTH = 8'b0011_0001;

    // Single-lane evaluation by table lookup
    function automatic logic f(input logic a, input logic b, input logic c);
        return TRUTH[{a, b, c}];
    endfunction

    // Width of a field able to hold the count 0..w
    function automatic int ones_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : silly_function_pkg
`default_nettype wire

// File: rtl/silly_function_lane.sv
`default_nettype none
// ============================================================================
// Module      : silly_function_lane
// Description : One-bit combinational lane of the silly function.
// Revision    : 1.0 - initial release
// ============================================================================
module silly_function_lane (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic y_o
);

    // Minimised sum-of-products: any b=1 row is 0; with b=0 only {a=0,c=1} is 0
    assign y_o = ~b_i & (a_i | ~c_i);

endmodule : silly_function_lane
`default_nettype wire

// File: rtl/silly_function.sv
`default_nettype none
// ============================================================================
// Module      : silly_function
// Description : WIDTH-lane silly-function evaluator with a zero-latency
//               combinational result and a registered copy carrying a
//               valid strobe and a popcount of the set lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module silly_function
    import silly_function_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH-1:0]           c,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           y,
    output logic [WIDTH-1:0]           y_q,
    output logic                       out_valid,
    output logic [ones_w(WIDTH)-1:0]   ones_q
);

    localparam int OW = ones_w(WIDTH);

    logic [WIDTH-1:0] yq_q;
    logic [WIDTH-1:0] yq_d;
    logic [OW-1:0]    onesq_q;
    logic [OW-1:0]    onesq_d;
    logic             valid_q;
    logic             valid_d;
    logic [OW-1:0]    pop_w;

    // Lanes are fully independent, so the result is just WIDTH copies of one lane
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            silly_function_lane u_lane (
                .a_i (a[i]),
                .b_i (b[i]),
                .c_i (c[i]),
                .y_o (y[i])
            );
        end
    endgenerate

    // Popcount of the live combinational result (not the stored one)
    always_comb begin
        pop_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_w = pop_w + OW'(y[i]);
        end
    end

    // Capture on in_valid, otherwise hold; strobe follows in_valid
    always_comb begin
        yq_d    = yq_q;
        onesq_d = onesq_q;
        valid_d = in_valid;
        if (in_valid) begin
            yq_d    = y;
            onesq_d = pop_w;
        end
    end

    // Result registers; reset wins over a simultaneous in_valid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            yq_q    <= '0;
            onesq_q <= '0;
            valid_q <= 1'b0;
        end else begin
            yq_q    <= yq_d;
            onesq_q <= onesq_d;
            valid_q <= valid_d;
        end
    end

    assign y_q       = yq_q;
    assign ones_q    = onesq_q;
    assign out_valid = valid_q;

endmodule : silly_function
`default_nettype wire

// File: tb/tb_silly_function.sv
`default_nettype none
// ============================================================================
// Module      : tb_silly_function
// Description : Self-checking bench for silly_function at WIDTH = 1, 8, 64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_silly_function;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] a, b, c;
    logic        in_valid;

    always #5 clk = ~clk;

    logic        y1, yq1, v1, ones1;
    logic [7:0]  y8, yq8;
    logic        v8;
    logic [3:0]  ones8;
    logic [63:0] y64, yq64;
    logic        v64;
    logic [6:0]  ones64;

    silly_function #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .a(a[0]), .b(b[0]), .c(c[0]),
        .in_valid(in_valid), .y(y1), .y_q(yq1), .out_valid(v1), .ones_q(ones1)
    );

    silly_function #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_n(reset_n), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
        .in_valid(in_valid), .y(y8), .y_q(yq8), .out_valid(v8), .ones_q(ones8)
    );

    silly_function #(.WIDTH(64)) u_w64 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .y(y64), .y_q(yq64), .out_valid(v64), .ones_q(ones64)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: what the registered outputs should hold
    logic [63:0] m_yq;
    logic        m_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-lane truth-table lookup, straight from the listed rows
    function automatic logic [63:0] ref_y(input logic [63:0] ra, input logic [63:0] rb,
                                          input logic [63:0] rc);
        logic [7:0]  tt;
        logic [63:0] r;
        tt = 8'b0011_0001;
        for (int i = 0; i < 64; i++) r[i] = tt[{ra[i], rb[i], rc[i]}];
        return r;
    endfunction

    // Check combinational outputs, clock once, update model, check registers
    task automatic step();
        logic [63:0] e;
        #1;
        e = ref_y(a, b, c);
        chk("y_w1", 64'(y1), 64'(e[0]));
        chk("y_w8", 64'(y8), 64'(e[7:0]));
        chk("y_w64", y64, e);
        @(posedge clk);
        if (!reset_n) begin
            m_yq = '0;
            m_v  = 1'b0;
        end else begin
            m_v = in_valid;
            if (in_valid) m_yq = e;
        end
        #1;
        chk("yq_w1", 64'(yq1), 64'(m_yq[0]));
        chk("ones_w1", 64'(ones1), 64'($countones(m_yq[0])));
        chk("v_w1", 64'(v1), 64'(m_v));
        chk("yq_w8", 64'(yq8), 64'(m_yq[7:0]));
        chk("ones_w8", 64'(ones8), 64'($countones(m_yq[7:0])));
        chk("v_w8", 64'(v8), 64'(m_v));
        chk("yq_w64", yq64, m_yq);
        chk("ones_w64", 64'(ones64), 64'($countones(m_yq)));
        chk("v_w64", 64'(v64), 64'(m_v));
    endtask

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [7:0] a, b, c;
        logic [7:0] exp_y;
        logic [7:0] exp_yq;
        logic [3:0] exp_ones;
        logic       exp_v;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // rst_n iv  a      b      c      y      y_q    ones v
        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 4'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'hF0, 8'hCC, 8'hAA, 8'h31, 8'h31, 4'd3, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 8'hF0, 8'hCC, 8'hAA, 8'h31, 8'h31, 4'd3, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 4'd8, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 4'd8, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 4'd0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h0F, 8'h00, 8'hF0, 8'h0F, 8'h00, 4'd0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 8'h0F, 8'h00, 8'hF0, 8'h0F, 8'h0F, 4'd4, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 4'd0, 1'b0};

        m_yq     = '0;
        m_v      = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; c = '0;

        // Combinational result exists before any clock edge
        #1;
        chk("w1_comb_noclk", 64'(y1), 64'd1);

        // Directed table on the 8-lane instance (inputs replicated to all widths)
        for (int i = 0; i < 10; i++) begin
            reset_n  = vecs[i].rst_n;
            in_valid = vecs[i].iv;
            a = {8{vecs[i].a}};
            b = {8{vecs[i].b}};
            c = {8{vecs[i].c}};
            step();
            chk($sformatf("tbl%0d_y", i), 64'(y8), 64'(vecs[i].exp_y));
            chk($sformatf("tbl%0d_yq", i), 64'(yq8), 64'(vecs[i].exp_yq));
            chk($sformatf("tbl%0d_ones", i), 64'(ones8), 64'(vecs[i].exp_ones));
            chk($sformatf("tbl%0d_v", i), 64'(v8), 64'(vecs[i].exp_v));
        end

        // Back-to-back sweep of all eight {a,b,c} combinations
        reset_n  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            logic [7:0] tt;
            tt = 8'b0011_0001;
            kk = 3'(k);
            a = {64{kk[2]}};
            b = {64{kk[1]}};
            c = {64{kk[0]}};
            step();
            chk($sformatf("sweep%0d_v", k), 64'(v8), 64'd1);
            chk($sformatf("sweep%0d_yq1", k), 64'(yq1), 64'(tt[kk]));
        end

        // Full 64-lane popcount must reach 64 without overflow
        a = '0; b = '0; c = '0;
        step();
        chk("w64_ones_full", 64'(ones64), 64'd64);
        chk("w1_ones_eq_yq", 64'(ones1), 64'(yq1));

        // Randomised traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            reset_n  = ($urandom_range(0, 15) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_silly_function
`default_nettype wire

// File: doc/silly_function.md
Name: silly_function

Overview:
- Bit-sliced evaluator of the 3-input "silly function" y = a'b'c' + ab'c' + ab'c, which minimises to y = ~b & (a | ~c).
- Provides a combinational result for immediate use and a registered copy with a valid strobe and a popcount.
- Sits in the logic-examples area as a reference combinational-plus-register block for lab exercises and bring-up.

Parameters:
- WIDTH, 1, number of independent lanes; lane i uses a[i], b[i], c[i] and drives y[i]; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- a  input  WIDTH  operand a per lane.
- b  input  WIDTH  operand b per lane.
- c  input  WIDTH  operand c per lane.
- in_valid  input  1  qualifies a/b/c for the registered path.
- y  output  WIDTH  combinational result per lane.
- y_q  output  WIDTH  registered result per lane.
- out_valid  output  1  y_q/ones_q hold a fresh result.
- ones_q  output  $clog2(WIDTH+1)  number of 1 bits in y_q.

Behaviour:
- Truth table per lane, indexed by {a,b,c}:
  - 000 -> 1, 001 -> 0, 010 -> 0, 011 -> 0.
  - 100 -> 1, 101 -> 1, 110 -> 0, 111 -> 0.
  - Packed as the 8-bit constant TRUTH = 8'b0011_0001 (bit index = {a,b,c}).
- Combinational path:
  - y = ~b & (a | ~c), bitwise across lanes.
  - Zero latency; independent of clk and reset_n, so it is valid during reset.
  - No X-pessimism handling is required.
- Registered path:
  - Each rising clk with reset_n=1 and in_valid=1: y_q <= y, ones_q <= popcount(y), out_valid <= 1. Latency is 1 cycle.
  - With in_valid=0: y_q and ones_q hold their values; out_valid <= 0.
  - out_valid is a one-cycle pulse per accepted input. There is no backpressure; back-to-back in_valid gives results every cycle.
- Reset:
  - On a rising clk with reset_n=0: y_q <= 0, ones_q <= 0, out_valid <= 0.
  - Reset has priority over a simultaneous in_valid; that input is dropped.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears 1 cycle after the first accepted input following reset release.
- Width rules:
  - ones_q is wide enough to hold WIDTH; for WIDTH=1, ones_q is 1 bit and equals y_q.
  - The popcount is computed from the combinational y at the same edge, not from the prior y_q.

Decomposition:
- Package silly_function_pkg:
  - TRUTH constant (8'b0011_0001).
  - function f(a,b,c) returning TRUTH[{a,b,c}].
  - function ones_w(WIDTH) returning $clog2(WIDTH+1).
- Sub-module silly_function_lane: one-bit combinational lane computing y from a, b, c, instantiated WIDTH times via generate.
- Registers and popcount live in the top level.

Test Plan:
- WIDTH=1, a=0 b=0 c=0 -> y=1 after 1 time unit with no clock; with in_valid=1 and one edge -> y_q=1, ones_q=1, out_valid=1.
- WIDTH=1, a=1 b=1 c=1 -> y=0; after an edge with in_valid -> y_q=0, ones_q=0.
- WIDTH=8, lane i = {a,b,c}=i (a=8'hF0, b=8'hCC, c=8'hAA) -> y=8'h31; next edge -> y_q=8'h31, ones_q=3, out_valid=1; a following idle cycle -> out_valid=0 with y_q held.
- reset_n=0 together with in_valid=1 and a=b=c=0 -> y=1 combinationally, but after the edge y_q=0, ones_q=0, out_valid=0.
- Exhaustive sweep of all 8 {a,b,c} combinations, back-to-back with in_valid=1 -> each y_q matches TRUTH one cycle later; out_valid stays high continuously.
- WIDTH=64, all lanes 000 -> y all ones; ones_q=64 one cycle later (7-bit field, no overflow).
